// File: rtl/ef_gpio8_drv_if.sv
// Bus-side interface for ef_gpio8_drv: register writes, per-pin strobes,
// pulse launch controls and the pad-facing outputs.
//   master : bus wrapper (drives writes/strobes, observes pad state)
//   slave  : ef_gpio8_drv
interface ef_gpio8_drv_if #(
  parameter int unsigned PW_W = 16
);
  logic [7:0]      out_wdata;
  logic            out_we;
  logic [7:0]      set;
  logic [7:0]      clr;
  logic [7:0]      tgl;
  logic [7:0]      oe_wdata;
  logic            oe_we;
  logic [7:0]      pulse_start;
  logic [PW_W-1:0] pulse_width;
  logic [7:0]      io_out;
  logic [7:0]      io_oe;
  logic [7:0]      pulse_busy;
  logic [7:0]      pulse_done;

  modport master (
    output out_wdata, out_we, set, clr, tgl, oe_wdata, oe_we,
           pulse_start, pulse_width,
    input  io_out, io_oe, pulse_busy, pulse_done
  );

  modport slave (
    input  out_wdata, out_we, set, clr, tgl, oe_wdata, oe_we,
           pulse_start, pulse_width,
    output io_out, io_oe, pulse_busy, pulse_done
  );
endinterface

// File: rtl/ef_gpio8_drv.sv
// ef_gpio8_drv: output/output-enable registers for one 8-pin GPIO port with
// atomic set/clear/toggle strobes and a per-pin one-shot pulse generator.
// A running pulse inverts the programmed level of its pin on io_out.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : out_wdata/out_we, set/clr/tgl, oe_wdata/oe_we,
//                 pulse_start/pulse_width in; io_out, io_oe,
//                 pulse_busy, pulse_done out (all registered)
// Build option: EF_GPIO8_DRV_RETRIG_EN -- pulse_start during a pulse reloads
// the counter (retrigger); otherwise it is ignored.
module ef_gpio8_drv #(
  parameter int unsigned PW_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ef_gpio8_drv_if.slave bus
);

  localparam int unsigned NPIN = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  state_t          state      [NPIN];
  state_t          state_next [NPIN];
  logic [PW_W-1:0] cnt        [NPIN];
  logic [PW_W-1:0] cnt_next   [NPIN];

  logic [7:0] out_reg;
  logic [7:0] out_reg_next;
  logic [7:0] busy_next;
  logic [7:0] done_next;
  logic       width_nz;

  assign width_nz = (bus.pulse_width != '0);

  // Output register next value: clr > set > tgl > write > hold.
  always_comb begin
    out_reg_next = out_reg;
    for (int i = 0; i < NPIN; i++) begin
      if (bus.clr[i])      out_reg_next[i] = 1'b0;
      else if (bus.set[i]) out_reg_next[i] = 1'b1;
      else if (bus.tgl[i]) out_reg_next[i] = ~out_reg[i];
      else if (bus.out_we) out_reg_next[i] = bus.out_wdata[i];
    end
  end

  // Per-pin pulse FSM next state; the counter stops at 1, so it never wraps.
  always_comb begin
    busy_next = '0;
    done_next = '0;
    for (int i = 0; i < NPIN; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      if (state[i] == IDLE) begin
        if (bus.pulse_start[i] && width_nz) begin
          state_next[i] = PULSE;
          cnt_next[i]   = bus.pulse_width;
        end
      end else begin
`ifdef EF_GPIO8_DRV_RETRIG_EN
        if (bus.pulse_start[i] && width_nz) begin
          cnt_next[i] = bus.pulse_width;
        end else
`endif
        if (cnt[i] > PW_W'(1)) begin
          cnt_next[i] = cnt[i] - PW_W'(1);
        end else begin
          state_next[i] = IDLE;
          cnt_next[i]   = '0;
          done_next[i]  = 1'b1;
        end
      end
      busy_next[i] = (state_next[i] == PULSE);
    end
  end

  // State, counters and registered pad outputs; io_out is a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPIN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      out_reg        <= '0;
      bus.io_out     <= '0;
      bus.io_oe      <= '0;
      bus.pulse_busy <= '0;
      bus.pulse_done <= '0;
    end else begin
      for (int i = 0; i < NPIN; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      out_reg        <= out_reg_next;
      bus.io_out     <= out_reg_next ^ busy_next;
      if (bus.oe_we) bus.io_oe <= bus.oe_wdata;
      bus.pulse_busy <= busy_next;
      bus.pulse_done <= done_next;
    end
  end

endmodule

// File: tb/tb_ef_gpio8_drv.sv
// Scoreboard bench for ef_gpio8_drv: the driver sets inputs mid-cycle and
// queues the hand-computed outputs expected after the next rising edge;
// the monitor pops and compares one entry per edge.
module tb_ef_gpio8_drv;

  localparam int unsigned PW_W = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   mon_idx;

  logic [31:0] exp_q [$];

  ef_gpio8_drv_if #(.PW_W(PW_W)) bus ();

  ef_gpio8_drv #(.PW_W(PW_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got out/oe/busy/done=%h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return {bus.io_out, bus.io_oe, bus.pulse_busy, bus.pulse_done};
  endfunction

  // Monitor: one expected entry per rising edge while the driver has queued one.
  initial begin
    mon_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check($sformatf("cycle_%0d", mon_idx), dut_outs(), e);
        mon_idx++;
      end
    end
  end

  // Queue the expected outputs for the coming edge, then clear one-cycle strobes.
  task automatic cyc(input logic [7:0] e_out, input logic [7:0] e_oe,
                     input logic [7:0] e_busy, input logic [7:0] e_done);
    exp_q.push_back({e_out, e_oe, e_busy, e_done});
    @(posedge clk);
    @(negedge clk);
    bus.out_we      = 1'b0;
    bus.oe_we       = 1'b0;
    bus.set         = '0;
    bus.clr         = '0;
    bus.tgl         = '0;
    bus.pulse_start = '0;
  endtask

  initial begin
    int last;
    total = 0;
    bad   = 0;
    bus.out_wdata   = '0;
    bus.out_we      = 1'b0;
    bus.set         = '0;
    bus.clr         = '0;
    bus.tgl         = '0;
    bus.oe_wdata    = '0;
    bus.oe_we       = 1'b0;
    bus.pulse_start = '0;
    bus.pulse_width = '0;
    rst_n = 1'b0;
    #1;
    check("reset_state", dut_outs(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle cycles, then write 0xA5 and oe 0x0F.
    for (int k = 0; k < 4; k++) cyc(8'h00, 8'h00, 8'h00, 8'h00);
    bus.out_wdata = 8'hA5; bus.out_we = 1'b1;
    cyc(8'hA5, 8'h00, 8'h00, 8'h00);
    bus.oe_wdata = 8'h0F; bus.oe_we = 1'b1;
    cyc(8'hA5, 8'h0F, 8'h00, 8'h00);

    // Simultaneous strobes: clr beats tgl on bit 0.
    bus.set = 8'h02; bus.clr = 8'h01; bus.tgl = 8'h81;
    cyc(8'h26, 8'h0F, 8'h00, 8'h00);

    // Width-3 pulse on pin 4 from out_reg = 0.
    bus.out_wdata = 8'h00; bus.out_we = 1'b1;
    cyc(8'h00, 8'h0F, 8'h00, 8'h00);
    bus.pulse_width = 16'd3; bus.pulse_start = 8'h10;
    cyc(8'h10, 8'h0F, 8'h10, 8'h00);
    cyc(8'h10, 8'h0F, 8'h10, 8'h00);
    cyc(8'h10, 8'h0F, 8'h10, 8'h00);
    cyc(8'h00, 8'h0F, 8'h00, 8'h10);
    cyc(8'h00, 8'h0F, 8'h00, 8'h00);

    // Width-2 pulse on pin 2 with a set during the pulse: stays inverted.
    bus.pulse_width = 16'd2; bus.pulse_start = 8'h04;
    cyc(8'h04, 8'h0F, 8'h04, 8'h00);
    bus.set = 8'h04;
    cyc(8'h00, 8'h0F, 8'h04, 8'h00);
    cyc(8'h04, 8'h0F, 8'h00, 8'h04);
    bus.clr = 8'h04;
    cyc(8'h00, 8'h0F, 8'h00, 8'h00);

    // Zero width launch on all pins is ignored.
    bus.pulse_width = 16'd0; bus.pulse_start = 8'hFF;
    cyc(8'h00, 8'h0F, 8'h00, 8'h00);
    cyc(8'h00, 8'h0F, 8'h00, 8'h00);

    // Width-5 pulse on pin 0 with a second start three cycles later.
`ifdef EF_GPIO8_DRV_RETRIG_EN
    last = 8;
`else
    last = 5;
`endif
    bus.pulse_width = 16'd5;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1 || k == 4) bus.pulse_start = 8'h01;
      cyc((k <= last) ? 8'h01 : 8'h00, 8'h0F,
          (k <= last) ? 8'h01 : 8'h00,
          (k == last + 1) ? 8'h01 : 8'h00);
    end

    // Width-10 pulse aborted by reset, then a normal width-2 pulse.
    bus.pulse_width = 16'd10; bus.pulse_start = 8'h01;
    for (int k = 1; k <= 4; k++) cyc(8'h01, 8'h0F, 8'h01, 8'h00);
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_pulse", dut_outs(), 32'h0);
    @(posedge clk);
    #1;
    check("held_in_reset", dut_outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'h00, 8'h00, 8'h00, 8'h00);
    bus.pulse_width = 16'd2; bus.pulse_start = 8'h08;
    cyc(8'h08, 8'h00, 8'h08, 8'h00);
    cyc(8'h08, 8'h00, 8'h08, 8'h00);
    cyc(8'h00, 8'h00, 8'h00, 8'h08);
    cyc(8'h00, 8'h00, 8'h00, 8'h00);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ef_gpio8_drv.md
# ef_gpio8_drv

Output-side companion to the 8-bit GPIO input block: owns the pad output and output-enable registers for one 8-pin port. Provides atomic per-pin set/clear/toggle strobes and a per-pin hardware one-shot pulse generator with a programmable width. The bus wrapper drives it, and `io_out`/`io_oe` connect directly to the pads.

## Interface
- `PW_W`, default 16: pulse width counter width in bits.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `out_wdata`  in  8  new output register value
- `out_we`  in  1  write strobe for `out_wdata`
- `set`  in  8  per-pin set strobe, one cycle
- `clr`  in  8  per-pin clear strobe, one cycle
- `tgl`  in  8  per-pin toggle strobe, one cycle
- `oe_wdata`  in  8  new output-enable value
- `oe_we`  in  1  write strobe for `oe_wdata`
- `pulse_start`  in  8  per-pin pulse launch strobe
- `pulse_width`  in  PW_W  pulse length in cycles; shared, sampled at launch
- `io_out`  out  8  pad output level, registered
- `io_oe`  out  8  pad output enable, registered
- `pulse_busy`  out  8  pin is currently pulsing
- `pulse_done`  out  8  one-cycle flag at the end of a pulse

## Operation
- `out_reg[i]` next-value priority, highest first: `clr` → 0, `set` → 1, `tgl` → invert, `out_we` → `out_wdata[i]`, else hold.
- `io_oe` loads `oe_wdata` on `oe_we`; otherwise it holds.
- Each pin has an independent FSM with two states, IDLE and PULSE, and a `PW_W`-bit down counter `cnt`.
- IDLE, with `pulse_start[i]` asserted and `pulse_width` ≠ 0: load `cnt = pulse_width` and go to PULSE.
- IDLE, with `pulse_start[i]` asserted and `pulse_width` = 0: ignored. No busy, no done.
- PULSE, `cnt` > 1: decrement.
- PULSE, `cnt` = 1: go to IDLE and assert `pulse_done[i]` for one cycle.
- `pulse_busy[i]` = (state == PULSE).
- `io_out[i]` is a flop loaded with `out_reg_next[i] ^ busy_next[i]`:
  - A pulse drives the inverse of the programmed level.
  - Register writes during a pulse take effect immediately, still inverted.
  - `io_out` is glitch-free because it is a single flop.
- `pulse_start` while in PULSE: behaviour is set by the macro below.
- Reset, asynchronous, including mid-pulse: `out_reg`, `io_out`, `io_oe`, `pulse_busy`, `pulse_done`, and `cnt` all go to 0, and every FSM goes to IDLE. No `pulse_done` is emitted for an aborted pulse.

## Timing
- Register write, strobe, or `oe_we` at cycle N: `io_out`/`io_oe` reflect it at N+1.
- `pulse_start` at N with width W: `io_out` is inverted and `pulse_busy` is high for cycles N+1 … N+W. At N+W+1 `io_out` is restored and `pulse_done` is high for that one cycle.
- W = 2^PW_W − 1 is the maximum. There is no wrap, because the counter never decrements below 1.
- Simultaneous `pulse_start` on several pins: all launch in the same cycle with the same width.
- `tgl` and `clr` on the same pin in the same cycle: clear wins.

## Configuration
- `EF_GPIO8_DRV_RETRIG_EN` defined: `pulse_start[i]` during PULSE reloads `cnt` with `pulse_width`, extending the pulse. No `pulse_done` is produced for the interrupted portion. With width 0, the restart is ignored and the pulse continues.
- `EF_GPIO8_DRV_RETRIG_EN` undefined: `pulse_start[i]` during PULSE is ignored and the pulse ends on its original schedule.

## Test plan
- Reset, then `out_we` with 0xA5 at cycle 5 → `io_out` = 0x00 before cycle 6, 0xA5 from cycle 6. `oe_we` with 0x0F → `io_oe` = 0x0F next cycle.
- `io_out` = 0xA5; in the same cycle `set` = 0x02, `clr` = 0x01, `tgl` = 0x81 → `io_out` = 0x26. Bit 0 cleared (clr beats tgl), bit 1 set, bit 7 toggled.
- `out_reg` = 0x00, `pulse_width` = 3, `pulse_start` = 0x10 at N → `io_out[4]` = 1 and `pulse_busy[4]` = 1 at N+1..N+3. `io_out[4]` = 0 and `pulse_done[4]` = 1 at N+4 only.
- `pulse_width` = 0 with `pulse_start` = 0xFF → no change on `io_out`, `pulse_busy`, or `pulse_done`.
- Width 5 pulse on pin 0; second `pulse_start[0]` with width 5 at N+3:
  - With `EF_GPIO8_DRV_RETRIG_EN`: busy through N+8, done at N+9.
  - Without it: busy through N+5, done at N+6.
- Width 10 pulse in progress; `rst_n` low at N+4 → all outputs 0 immediately and no `pulse_done`. After release, a new width-2 pulse works normally.
